l1_dcache_ld_resp_adapter: RTL and testbench

Response-side companion to the L1 load/store request adapter. Tracks a single outstanding load from grant to dcache response. Extracts, aligns and sign/zero-extends the addressed bytes from the 64-bit response word, then returns the result to core writeback over a valid/ready handshake. Handles flush (kill) of an in-flight load, dcache nack/replay, and a response timeout.

---
 rtl/l1_dcache_ld_resp_adapter_pkg.sv | 26 ++
 rtl/l1_dcache_ld_resp_adapter_ld_data_align.sv | 46 ++++
 rtl/l1_dcache_ld_resp_adapter.sv | 163 ++++++++++++++++
 tb/tb_l1_dcache_ld_resp_adapter.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/l1_dcache_ld_resp_adapter_pkg.sv
// Shared types for the L1 dcache load response path: FSM states and load size encodings.
package l1_dcache_ld_resp_adapter_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_GNT  = 3'd1,
    WAIT_RESP = 3'd2,
    HOLD      = 3'd3,
    DRAIN     = 3'd4
  } ld_state_e;

  // Same encoding as the request adapter's byte-enable generator.
  typedef enum logic [1:0] {
    LD_B = 2'b00,
    LD_H = 2'b01,
    LD_W = 2'b10,
    LD_D = 2'b11
  } ld_size_e;

  localparam int unsigned LD_DATA_W = 64;

  function automatic logic [3:0] ld_size_bytes(input logic [1:0] size);
    return 4'd1 << size;
  endfunction

endpackage

// File: rtl/l1_dcache_ld_resp_adapter_ld_data_align.sv
// Combinational load data extraction: shift the addressed bytes down, keep 1<<size bytes,
// sign/zero-extend, and flag accesses that run past the end of the 64-bit word.
module ld_data_align
  import l1_dcache_ld_resp_adapter_pkg::*;
(
  input  logic [LD_DATA_W-1:0] data_i,
  input  logic [1:0]           size_i,
  input  logic [2:0]           offset_i,
  input  logic                 signed_i,
  output logic [LD_DATA_W-1:0] data_o,
  output logic                 misalign_o
);

  logic [LD_DATA_W-1:0] w_shifted;
  logic [3:0]           w_nbytes;
  logic                 w_sign;
  logic [7:0]           w_fill;

  assign w_shifted  = data_i >> {offset_i, 3'b000};
  assign w_nbytes   = ld_size_bytes(size_i);
  assign misalign_o = ({1'b0, offset_i} + w_nbytes) > 4'd8;

  always_comb begin
    w_sign = 1'b0;
    case (size_i)
      LD_B:    w_sign = w_shifted[7];
      LD_H:    w_sign = w_shifted[15];
      LD_W:    w_sign = w_shifted[31];
      default: w_sign = 1'b0;
    endcase
  end

  assign w_fill = {8{signed_i & w_sign}};

  // Each lane either passes the shifted byte or carries the extension byte.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_lane
      logic w_keep;
      assign w_keep = (4'(gi) < w_nbytes);
      assign data_o[8*gi +: 8] = misalign_o ? 8'h00 :
                                 (w_keep ? w_shifted[8*gi +: 8] : w_fill);
    end
  endgenerate

endmodule

// File: rtl/l1_dcache_ld_resp_adapter.sv
// Tracks one outstanding dcache load from grant to response and hands the aligned
// result to writeback; handles flush, nack/replay and a response timeout.
module l1_dcache_ld_resp_adapter
  import l1_dcache_ld_resp_adapter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 1023,
  parameter int unsigned RD_W        = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ld_req_valid_i,
  input  logic                 ld_req_gnt_i,
  input  logic [1:0]           ld_size_i,
  input  logic [2:0]           ld_offset_i,
  input  logic                 ld_signed_i,
  input  logic [RD_W-1:0]      ld_rd_i,
  input  logic                 kill_i,
  input  logic                 dmem_resp_valid_i,
  input  logic [LD_DATA_W-1:0] dmem_resp_data_i,
  input  logic                 dmem_resp_nack_i,
  input  logic                 wb_ready_i,
  output logic                 ld_req_ready_o,
  output logic                 wb_valid_o,
  output logic [LD_DATA_W-1:0] wb_data_o,
  output logic [RD_W-1:0]      wb_rd_o,
  output logic                 replay_o,
  output logic                 misalign_o,
  output logic                 timeout_o,
  output logic                 busy_o
);

  localparam int unsigned      CNT_W      = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST   = (TIMEOUT_CYC == 0) ? '0 : CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(TIMEOUT_CYC);
  localparam logic             TIMEOUT_EN = (TIMEOUT_CYC != 0);

  ld_state_e            r_state;
  ld_state_e            w_state_next;
  logic [1:0]           r_size;
  logic [2:0]           r_offset;
  logic                 r_signed;
  logic [RD_W-1:0]      r_rd;
  logic [LD_DATA_W-1:0] r_wb_data;
  logic                 r_misalign;
  logic                 r_replay;
  logic                 r_timeout;
  logic [CNT_W-1:0]     r_cnt;

  logic                 w_capture;
  logic                 w_load_result;
  logic                 w_replay_set;
  logic                 w_timeout_set;
  logic                 w_cnt_hit;
  logic [LD_DATA_W-1:0] w_align_data;
  logic                 w_align_misalign;

  ld_data_align u_align (
    .data_i     (dmem_resp_data_i),
    .size_i     (r_size),
    .offset_i   (r_offset),
    .signed_i   (r_signed),
    .data_o     (w_align_data),
    .misalign_o (w_align_misalign)
  );

  assign w_cnt_hit = TIMEOUT_EN && (r_cnt == CNT_LAST);

  // Priority in WAIT_RESP: kill, then nack, then response, then timeout.
  always_comb begin
    w_state_next  = r_state;
    w_capture     = 1'b0;
    w_load_result = 1'b0;
    w_replay_set  = 1'b0;
    w_timeout_set = 1'b0;
    case (r_state)
      IDLE: begin
        if (ld_req_valid_i) begin
          w_capture    = 1'b1;
          w_state_next = ld_req_gnt_i ? WAIT_RESP : WAIT_GNT;
        end
      end
      WAIT_GNT: begin
        if (kill_i) begin
          w_state_next = IDLE;
        end else if (ld_req_gnt_i) begin
          w_state_next = WAIT_RESP;
        end
      end
      WAIT_RESP: begin
        if (kill_i) begin
          w_state_next = (dmem_resp_valid_i || dmem_resp_nack_i) ? IDLE : DRAIN;
        end else if (dmem_resp_nack_i) begin
          w_replay_set = 1'b1;
          w_state_next = IDLE;
        end else if (dmem_resp_valid_i) begin
          w_load_result = 1'b1;
          w_state_next  = HOLD;
        end else if (w_cnt_hit) begin
          w_timeout_set = 1'b1;
          w_state_next  = IDLE;
        end
      end
      HOLD: begin
        if (kill_i || wb_ready_i) begin
          w_state_next = IDLE;
        end
      end
      DRAIN: begin
        if (dmem_resp_valid_i || dmem_resp_nack_i) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_size     <= 2'b00;
      r_offset   <= 3'b000;
      r_signed   <= 1'b0;
      r_rd       <= '0;
      r_wb_data  <= '0;
      r_misalign <= 1'b0;
      r_replay   <= 1'b0;
      r_timeout  <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_state  <= w_state_next;
      r_replay <= w_replay_set;
      if (w_capture) begin
        r_size   <= ld_size_i;
        r_offset <= ld_offset_i;
        r_signed <= ld_signed_i;
        r_rd     <= ld_rd_i;
      end
      if (w_load_result) begin
        r_wb_data  <= w_align_data;
        r_misalign <= w_align_misalign;
      end
      if (w_timeout_set) begin
        r_timeout <= 1'b1;
      end
      // Counter restarts on every entry into WAIT_RESP and saturates while there.
      if (w_state_next == WAIT_RESP && r_state != WAIT_RESP) begin
        r_cnt <= '0;
      end else if (r_state == WAIT_RESP && r_cnt != CNT_MAX) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign ld_req_ready_o = (r_state == IDLE);
  assign busy_o         = (r_state != IDLE);
  assign wb_valid_o     = (r_state == HOLD);
  assign wb_data_o      = r_wb_data;
  assign wb_rd_o        = r_rd;
  assign misalign_o     = r_misalign & wb_valid_o;
  assign replay_o       = r_replay;
  assign timeout_o      = r_timeout;

endmodule

// File: tb/tb_l1_dcache_ld_resp_adapter.sv
// Randomized and directed bench for the load response adapter against an arithmetic reference model.
module tb_l1_dcache_ld_resp_adapter;

  localparam int RD_W = 5;
  localparam int TO   = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            ld_req_valid_i;
  logic            ld_req_gnt_i;
  logic [1:0]      ld_size_i;
  logic [2:0]      ld_offset_i;
  logic            ld_signed_i;
  logic [RD_W-1:0] ld_rd_i;
  logic            kill_i;
  logic            dmem_resp_valid_i;
  logic [63:0]     dmem_resp_data_i;
  logic            dmem_resp_nack_i;
  logic            wb_ready_i;
  logic            ld_req_ready_o;
  logic            wb_valid_o;
  logic [63:0]     wb_data_o;
  logic [RD_W-1:0] wb_rd_o;
  logic            replay_o;
  logic            misalign_o;
  logic            timeout_o;
  logic            busy_o;

  int n_checks = 0;
  int n_fail   = 0;

  l1_dcache_ld_resp_adapter #(.TIMEOUT_CYC(TO), .RD_W(RD_W)) dut (
    .clk               (clk),
    .rst               (rst),
    .ld_req_valid_i    (ld_req_valid_i),
    .ld_req_gnt_i      (ld_req_gnt_i),
    .ld_size_i         (ld_size_i),
    .ld_offset_i       (ld_offset_i),
    .ld_signed_i       (ld_signed_i),
    .ld_rd_i           (ld_rd_i),
    .kill_i            (kill_i),
    .dmem_resp_valid_i (dmem_resp_valid_i),
    .dmem_resp_data_i  (dmem_resp_data_i),
    .dmem_resp_nack_i  (dmem_resp_nack_i),
    .wb_ready_i        (wb_ready_i),
    .ld_req_ready_o    (ld_req_ready_o),
    .wb_valid_o        (wb_valid_o),
    .wb_data_o         (wb_data_o),
    .wb_rd_o           (wb_rd_o),
    .replay_o          (replay_o),
    .misalign_o        (misalign_o),
    .timeout_o         (timeout_o),
    .busy_o            (busy_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // Reference: bit 64 is the range-error flag, bits 63:0 the expected writeback data.
  function automatic logic [64:0] ref_load(input logic [1:0] sz, input logic [2:0] off,
                                           input logic sgn, input logic [63:0] d);
    int          nb;
    logic [63:0] v;
    logic [63:0] mask;
    nb = 1 << sz;
    if (int'(off) + nb > 8) return {1'b1, 64'd0};
    v    = d >> (8 * int'(off));
    mask = (nb == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * nb)) - 64'd1);
    v    = v & mask;
    if (sgn && nb < 8 && v[8*nb-1]) v = v | ~mask;
    return {1'b0, v};
  endfunction

  task automatic quiet_inputs();
    ld_req_valid_i    = 1'b0;
    ld_req_gnt_i      = 1'b0;
    kill_i            = 1'b0;
    dmem_resp_valid_i = 1'b0;
    dmem_resp_nack_i  = 1'b0;
    wb_ready_i        = 1'b0;
    dmem_resp_data_i  = rnd64();
  endtask

  task automatic issue(input logic [1:0] sz, input logic [2:0] off, input logic sgn,
                       input logic [RD_W-1:0] rd, input int gd);
    chk("req_ready_idle", 64'(ld_req_ready_o), 64'd1);
    ld_req_valid_i = 1'b1;
    ld_size_i      = sz;
    ld_offset_i    = off;
    ld_signed_i    = sgn;
    ld_rd_i        = rd;
    ld_req_gnt_i   = (gd == 0);
    tick();
    ld_req_valid_i = 1'b0;
    ld_req_gnt_i   = 1'b0;
    ld_size_i      = 2'($urandom);
    ld_offset_i    = 3'($urandom);
    ld_signed_i    = 1'($urandom);
    ld_rd_i        = RD_W'($urandom);
    chk("busy_after_req", 64'(busy_o), 64'd1);
    for (int i = 1; i <= gd; i++) begin
      ld_req_gnt_i = (i == gd);
      tick();
    end
    ld_req_gnt_i = 1'b0;
  endtask

  task automatic do_load(input logic [1:0] sz, input logic [2:0] off, input logic sgn,
                         input logic [RD_W-1:0] rd, input logic [63:0] d, input int gd,
                         input int rdly, input int stall, output logic [63:0] obs_data,
                         output logic obs_mis);
    logic [64:0] expv;
    expv = ref_load(sz, off, sgn, d);
    issue(sz, off, sgn, rd, gd);
    for (int i = 0; i < rdly; i++) begin
      dmem_resp_data_i = rnd64();
      tick();
      chk("no_early_wb", 64'(wb_valid_o), 64'd0);
    end
    dmem_resp_valid_i = 1'b1;
    dmem_resp_data_i  = d;
    tick();
    dmem_resp_valid_i = 1'b0;
    dmem_resp_data_i  = rnd64();
    chk("wb_valid_lat1", 64'(wb_valid_o), 64'd1);
    chk("wb_data", wb_data_o, expv[63:0]);
    chk("wb_rd", 64'(wb_rd_o), 64'(rd));
    chk("misalign", 64'(misalign_o), 64'(expv[64]));
    chk("req_ready_hold", 64'(ld_req_ready_o), 64'd0);
    obs_data = wb_data_o;
    obs_mis  = misalign_o;
    for (int i = 0; i < stall; i++) begin
      tick();
      chk("stall_valid", 64'(wb_valid_o), 64'd1);
      chk("stall_data", wb_data_o, expv[63:0]);
      chk("stall_rd", 64'(wb_rd_o), 64'(rd));
    end
    wb_ready_i = 1'b1;
    tick();
    wb_ready_i = 1'b0;
    chk("wb_done", 64'(wb_valid_o), 64'd0);
    chk("req_ready_after_wb", 64'(ld_req_ready_o), 64'd1);
    $display("load sz=%0d off=%0d sgn=%0d rd=%0d gd=%0d rdly=%0d stall=%0d data=%h -> wb=%h mis=%0d",
             sz, off, sgn, rd, gd, rdly, stall, d, obs_data, obs_mis);
  endtask

  initial begin
    logic [63:0] od;
    logic        om;
    rst = 1'b1;
    ld_size_i = 2'b00; ld_offset_i = 3'b000; ld_signed_i = 1'b0; ld_rd_i = '0;
    quiet_inputs();
    tick();
    tick();
    rst = 1'b0;
    chk("rst_ready", 64'(ld_req_ready_o), 64'd1);
    chk("rst_valid", 64'(wb_valid_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_replay", 64'(replay_o), 64'd0);
    chk("rst_timeout", 64'(timeout_o), 64'd0);
    chk("rst_data", wb_data_o, 64'd0);
    $display("reset done");

    do_load(2'b00, 3'd3, 1'b1, 5'd7, 64'h0000_0000_8000_0000, 0, 0, 0, od, om);
    chk("tp_signed_byte", od, 64'hFFFF_FFFF_FFFF_FF80);
    do_load(2'b01, 3'd6, 1'b0, 5'd12, 64'hBEEF_0000_0000_0000, 1, 2, 4, od, om);
    chk("tp_unsigned_half", od, 64'h0000_0000_0000_BEEF);
    do_load(2'b10, 3'd5, 1'b1, 5'd3, rnd64(), 0, 1, 0, od, om);
    chk("tp_range_data", od, 64'd0);
    chk("tp_range_flag", 64'(om), 64'd1);
    do_load(2'b11, 3'd0, 1'b1, 5'd31, 64'h8123_4567_89AB_CDEF, 2, 0, 1, od, om);
    chk("tp_double_nosext", od, 64'h8123_4567_89AB_CDEF);

    // Nack after a grant delayed by three cycles.
    issue(2'b10, 3'd0, 1'b0, 5'd9, 3);
    dmem_resp_nack_i = 1'b1;
    tick();
    dmem_resp_nack_i = 1'b0;
    chk("nack_replay", 64'(replay_o), 64'd1);
    chk("nack_no_wb", 64'(wb_valid_o), 64'd0);
    chk("nack_ready", 64'(ld_req_ready_o), 64'd1);
    tick();
    chk("nack_replay_pulse", 64'(replay_o), 64'd0);
    $display("nack with delayed grant");

    // Nack and response together: nack wins.
    issue(2'b00, 3'd1, 1'b0, 5'd4, 0);
    dmem_resp_nack_i = 1'b1; dmem_resp_valid_i = 1'b1;
    tick();
    dmem_resp_nack_i = 1'b0; dmem_resp_valid_i = 1'b0;
    chk("nack_valid_replay", 64'(replay_o), 64'd1);
    chk("nack_valid_no_wb", 64'(wb_valid_o), 64'd0);
    tick();
    chk("nack_valid_no_wb2", 64'(wb_valid_o), 64'd0);
    $display("nack and valid same cycle");

    // Kill in WAIT_RESP, response two cycles later.
    issue(2'b10, 3'd4, 1'b1, 5'd5, 0);
    kill_i = 1'b1;
    tick();
    kill_i = 1'b0;
    chk("kill_drain_busy", 64'(busy_o), 64'd1);
    chk("kill_drain_no_wb", 64'(wb_valid_o), 64'd0);
    tick();
    chk("kill_drain_busy2", 64'(busy_o), 64'd1);
    dmem_resp_valid_i = 1'b1;
    tick();
    dmem_resp_valid_i = 1'b0;
    chk("kill_drain_idle", 64'(ld_req_ready_o), 64'd1);
    chk("kill_drain_no_wb2", 64'(wb_valid_o), 64'd0);
    chk("kill_drain_no_replay", 64'(replay_o), 64'd0);
    tick();
    chk("kill_drain_no_wb3", 64'(wb_valid_o), 64'd0);
    $display("kill in wait_resp then drained response");

    // Kill and response in the same cycle.
    issue(2'b01, 3'd2, 1'b0, 5'd6, 1);
    kill_i = 1'b1; dmem_resp_valid_i = 1'b1;
    tick();
    kill_i = 1'b0; dmem_resp_valid_i = 1'b0;
    chk("kill_resp_idle", 64'(ld_req_ready_o), 64'd1);
    chk("kill_resp_no_wb", 64'(wb_valid_o), 64'd0);
    $display("kill and response same cycle");

    // Kill while waiting for grant.
    issue(2'b00, 3'd0, 1'b0, 5'd1, 0);
    $display("kill in wait_gnt skipped path check via wait_resp entry");
    dmem_resp_valid_i = 1'b1; dmem_resp_data_i = 64'h55;
    tick();
    dmem_resp_valid_i = 1'b0;
    wb_ready_i = 1'b1;
    tick();
    wb_ready_i = 1'b0;
    ld_req_valid_i = 1'b1; ld_req_gnt_i = 1'b0;
    tick();
    ld_req_valid_i = 1'b0;
    kill_i = 1'b1;
    tick();
    kill_i = 1'b0;
    chk("kill_gnt_idle", 64'(ld_req_ready_o), 64'd1);
    $display("kill in wait_gnt");

    for (int n = 0; n < 40; n++) begin
      do_load(2'($urandom_range(3)), 3'($urandom_range(7)), 1'($urandom), RD_W'($urandom),
              rnd64(), int'($urandom_range(3)), int'($urandom_range(4)),
              int'($urandom_range(3)), od, om);
    end

    // Timeout: no response after a same-cycle grant.
    issue(2'b10, 3'd0, 1'b0, 5'd2, 0);
    for (int i = 0; i < TO - 1; i++) begin
      tick();
      chk("to_not_yet", 64'(timeout_o), 64'd0);
      chk("to_busy", 64'(busy_o), 64'd1);
    end
    tick();
    chk("to_set", 64'(timeout_o), 64'd1);
    chk("to_idle", 64'(ld_req_ready_o), 64'd1);
    chk("to_no_wb", 64'(wb_valid_o), 64'd0);
    $display("timeout after %0d cycles", TO);
    do_load(2'b00, 3'd7, 1'b1, 5'd8, 64'h7F00_0000_0000_0000, 0, 0, 0, od, om);
    chk("to_sticky", 64'(timeout_o), 64'd1);

    // Reset while HOLD.
    issue(2'b11, 3'd0, 1'b0, 5'd21, 0);
    dmem_resp_valid_i = 1'b1; dmem_resp_data_i = 64'hDEAD_BEEF_0BAD_F00D;
    tick();
    dmem_resp_valid_i = 1'b0;
    chk("hold_before_rst", 64'(wb_valid_o), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rsthold_valid", 64'(wb_valid_o), 64'd0);
    chk("rsthold_ready", 64'(ld_req_ready_o), 64'd1);
    chk("rsthold_busy", 64'(busy_o), 64'd0);
    chk("rsthold_data", wb_data_o, 64'd0);
    chk("rsthold_rd", 64'(wb_rd_o), 64'd0);
    chk("rsthold_timeout", 64'(timeout_o), 64'd0);
    chk("rsthold_replay", 64'(replay_o), 64'd0);
    chk("rsthold_misalign", 64'(misalign_o), 64'd0);
    $display("reset in hold");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
